dvbc_interleaver_ctrl: RTL and testbench

//  Scheduler/address generator for the DVB-C convolutional interleaver (EN 300429, I=12, M=17).

---
 rtl/dvbc_pkg.sv | 28 ++
 rtl/dvbc_intlv_ptr_bank.sv | 36 +++
 rtl/dvbc_interleaver_ctrl.sv | 113 +++++++++++
 tb/tb_dvbc_interleaver_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dvbc_pkg.sv
// Shared constants, FSM encoding and branch base-address helper for the
// DVB-C convolutional interleaver (I=12, M=17).
package dvbc_pkg;

  localparam int unsigned DVBC_I       = 12;
  localparam int unsigned DVBC_M       = 17;
  localparam int unsigned DVBC_PKT_LEN = 204;
  localparam int unsigned DVBC_CELLS   = DVBC_M * DVBC_I * (DVBC_I - 1) / 2;

  localparam logic [7:0] DVBC_SYNC     = 8'h47;
  localparam logic [7:0] DVBC_SYNC_INV = 8'hB8;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef enum logic [1:0] {
    S_INIT  = ST_INIT,
    S_ALIGN = ST_ALIGN,
    S_RUN   = ST_RUN
  } state_t;

  // First RAM cell of branch j: branches 1..j-1 hold M*(1+..+(j-1)) cells before it.
  function automatic int unsigned dvbc_intlv_base(input int unsigned j);
    return (j == 0) ? 0 : DVBC_M * j * (j - 1) / 2;
  endfunction

endpackage

// File: rtl/dvbc_intlv_ptr_bank.sv
// Per-branch circular FIFO pointers for branches 1..I-1; branch j wraps at j*M-1.
module dvbc_intlv_ptr_bank #(
  parameter int unsigned BRANCHES = 12,
  parameter int unsigned DEPTH_M  = 17,
  parameter int unsigned BR_W     = 4,
  parameter int unsigned PTR_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [BR_W-1:0]  branch,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q [1:BRANCHES-1];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int j = 1; j < BRANCHES; j++) ptr_q[j] <= '0;
    end else if (advance) begin
      for (int j = 1; j < BRANCHES; j++) begin
        if (branch == BR_W'(j))
          ptr_q[j] <= (ptr_q[j] == PTR_W'(j * DEPTH_M - 1)) ? '0 : ptr_q[j] + PTR_W'(1);
      end
    end
  end

  // Branch 0 has no FIFO; it reads as pointer 0.
  always_comb begin
    ptr = '0;
    for (int j = 1; j < BRANCHES; j++) begin
      if (branch == BR_W'(j)) ptr = ptr_q[j];
    end
  end

endmodule

// File: rtl/dvbc_interleaver_ctrl.sv
// DVB-C convolutional interleaver scheduler: clears the shared branch RAM,
// aligns on packet sync, then steers bytes round-robin over the 12 branches.
module dvbc_interleaver_ctrl
  import dvbc_pkg::*;
#(
  parameter int unsigned BRANCHES = DVBC_I,
  parameter int unsigned DEPTH_M  = DVBC_M,
  parameter int unsigned PKT_LEN  = DVBC_PKT_LEN,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              sync_i,
  output logic              ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              sync_o,
  output logic              sync_err_o
);

  localparam int unsigned BR_W  = $clog2(BRANCHES);
  localparam int unsigned CNT_W = $clog2(PKT_LEN);
  localparam int unsigned PTR_W = $clog2(DEPTH_M * (BRANCHES - 1));
  localparam int unsigned CELLS = DEPTH_M * BRANCHES * (BRANCHES - 1) / 2;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr, addr_q, acc_addr;
  logic [BR_W-1:0]   branch, cur_br;
  logic [CNT_W-1:0]  byte_cnt, cur_cnt;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] byp_q;
  logic              valid_q, sync_q, err_q, ram_sel_q;
  logic              accept, proc, sync_err, restart, ram_acc;

  // A misplaced sync (or the first sync in ALIGN) restarts the byte at branch 0 / byte 0.
  always_comb begin
    accept   = valid_i & (state != S_INIT) & ~rst_i;
    proc     = accept & ((state == S_RUN) | sync_i);
    sync_err = accept & (state == S_RUN) & sync_i & (byte_cnt != '0);
    restart  = (state == S_ALIGN) | sync_err;
    cur_br   = restart ? '0 : branch;
    cur_cnt  = restart ? '0 : byte_cnt;
    ram_acc  = proc & (cur_br != '0);
    acc_addr = ADDR_W'(dvbc_intlv_base(32'(cur_br))) + ADDR_W'(ptr);
  end

  dvbc_intlv_ptr_bank #(
    .BRANCHES (BRANCHES),
    .DEPTH_M  (DEPTH_M),
    .BR_W     (BR_W),
    .PTR_W    (PTR_W)
  ) u_ptr_bank (
    .clk     (clk_i),
    .clear   (rst_i),
    .branch  (cur_br),
    .advance (ram_acc),
    .ptr     (ptr)
  );

  // RAM strobes must coincide with the accepted byte; the read returns next cycle.
  always_comb begin
    ready_o     = (state != S_INIT) & ~rst_i;
    ram_we_o    = ~rst_i & ((state == S_INIT) | ram_acc);
    ram_wdata_o = (state == S_INIT) ? '0 : data_i;
    ram_addr_o  = (state == S_INIT) ? clr_addr : (ram_acc ? acc_addr : addr_q);
    data_o      = ram_sel_q ? ram_rdata_i : byp_q;
    valid_o     = valid_q;
    sync_o      = sync_q;
    sync_err_o  = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_INIT;
      clr_addr  <= '0;
      branch    <= '0;
      byte_cnt  <= '0;
      addr_q    <= '0;
      byp_q     <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
      ram_sel_q <= 1'b0;
    end else begin
      addr_q    <= ram_addr_o;
      valid_q   <= proc;
      sync_q    <= proc & (cur_cnt == '0);
      err_q     <= sync_err;
      ram_sel_q <= ram_acc;
      if (proc && (cur_br == '0)) byp_q <= data_i;
      if (proc) begin
        branch   <= (cur_br == BR_W'(BRANCHES - 1)) ? '0 : cur_br + BR_W'(1);
        byte_cnt <= (cur_cnt == CNT_W'(PKT_LEN - 1)) ? '0 : cur_cnt + CNT_W'(1);
      end
      case (state)
        S_INIT: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(CELLS - 1)) state <= S_ALIGN;
        end
        S_ALIGN: if (proc) state <= S_RUN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dvbc_interleaver_ctrl.sv
// Bench for dvbc_interleaver_ctrl: RAM model, per-branch delay-line reference
// model with an output scoreboard, and an address table for the pointer wraps.
module tb_dvbc_interleaver_ctrl;
  import dvbc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, sync_i;
  logic [7:0]  data_i, ram_wdata_o, ram_rdata_i, data_o;
  logic [10:0] ram_addr_o;
  logic        ready_o, ram_we_o, valid_o, sync_o, sync_err_o;

  always #5 clk = ~clk;

  dvbc_interleaver_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sync_i      (sync_i),
    .ready_o     (ready_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .sync_o      (sync_o),
    .sync_err_o  (sync_err_o)
  );

  // Single-port read-first RAM
  logic [7:0] mem [0:1121];
  always @(posedge clk) begin
    ram_rdata_i <= mem[ram_addr_o];
    if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
  end

  typedef struct {
    logic [7:0]  data;
    logic        sync;
    logic        err;
    int unsigned stamp;
  } exp_t;

  typedef struct {
    int          n;
    logic        we;
    logic [10:0] addr;
  } vec_t;

  exp_t        sb[$];
  exp_t        me;
  vec_t        vt[12];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc_n = 0;
  int          tbl_n = -1;

  bit          m_align;
  int          m_br, m_cnt;
  int          m_vis[12];
  logic [7:0]  hist[12][1024];
  logic [10:0] last_addr;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int base(input int j);
    return 17 * j * (j - 1) / 2;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(valid_o), 0);
      else begin
        me = sb.pop_front();
        chk("out_latency", cyc_n, me.stamp);
        chk("data_o", 32'(data_o), 32'(me.data));
        chk("sync_o", 32'(sync_o), 32'(me.sync));
        chk("sync_err_o", 32'(sync_err_o), 32'(me.err));
      end
    end else if (sync_err_o) chk("stray_sync_err", 32'(sync_err_o), 0);
  end

  // One cycle: drive at posedge+1, check RAM strobes at negedge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic ewe,
                     input logic [10:0] eaddr, input logic push, input exp_t e);
    exp_t ee;
    ee = e;
    valid_i = v; sync_i = s; data_i = d;
    if (push) begin ee.stamp = cyc_n + 1; sb.push_back(ee); end
    @(negedge clk);
    chk("ready_o", 32'(ready_o), 1);
    chk("ram_we_o", 32'(ram_we_o), 32'(ewe));
    chk("ram_addr_o", 32'(ram_addr_o), 32'(eaddr));
    if (ewe) chk("ram_wdata_o", 32'(ram_wdata_o), 32'(d));
    for (int i = 0; i < 12; i++) begin
      if (vt[i].n == tbl_n) begin
        chk("tbl_we", 32'(ram_we_o), 32'(vt[i].we));
        chk("tbl_addr", 32'(ram_addr_o), 32'(vt[i].addr));
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0; sync_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    exp_t        e;
    int          br, cnt, v;
    logic        we, push;
    logic [10:0] addr;
    e = '{data: 8'h00, sync: 1'b0, err: 1'b0, stamp: 0};
    we = 1'b0; addr = last_addr; push = 1'b0;
    if (!(m_align && !s)) begin
      e.err = !m_align && s && (m_cnt != 0);
      if (m_align || e.err) begin br = 0; cnt = 0; end
      else begin br = m_br; cnt = m_cnt; end
      m_align = 1'b0;
      if (br == 0) e.data = d;
      else begin
        v = m_vis[br];
        we = 1'b1;
        addr = 11'(base(br) + v % (br * 17));
        last_addr = addr;
        hist[br][v] = d;
        e.data = (v >= br * 17) ? hist[br][v - br * 17] : 8'h00;
        m_vis[br] = v + 1;
      end
      e.sync = (cnt == 0);
      push = 1'b1;
      m_br  = (br == 11) ? 0 : br + 1;
      m_cnt = (cnt == 203) ? 0 : cnt + 1;
    end
    cyc(1'b1, s, d, we, addr, push, e);
  endtask

  task automatic idle();
    exp_t e;
    e = '{data: 8'h00, sync: 1'b0, err: 1'b0, stamp: 0};
    cyc(1'b0, 1'b0, 8'($urandom), 1'b0, last_addr, 1'b0, e);
  endtask

  task automatic reset_and_init(input int hold);
    rst_i = 1'b1; valid_i = 1'b0; sync_i = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_sync", 32'(sync_o), 0);
    chk("rst_sync_err", 32'(sync_err_o), 0);
    chk("rst_we", 32'(ram_we_o), 0);
    chk("rst_data", 32'(data_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int k = 0; k < 1122; k++) begin
      @(negedge clk);
      chk("init_ready", 32'(ready_o), 0);
      chk("init_we", 32'(ram_we_o), 1);
      chk("init_addr", 32'(ram_addr_o), 32'(k));
      chk("init_wdata", 32'(ram_wdata_o), 0);
      @(posedge clk); #1;
    end
    m_align = 1'b1; m_br = 0; m_cnt = 0; last_addr = 11'd1121;
    for (int j = 0; j < 12; j++) m_vis[j] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{n: 0,    we: 1'b0, addr: 11'd1121};
    vt[1]  = '{n: 1,    we: 1'b1, addr: 11'd0};
    vt[2]  = '{n: 2,    we: 1'b1, addr: 11'd17};
    vt[3]  = '{n: 5,    we: 1'b1, addr: 11'd170};
    vt[4]  = '{n: 7,    we: 1'b1, addr: 11'd357};
    vt[5]  = '{n: 11,   we: 1'b1, addr: 11'd935};
    vt[6]  = '{n: 12,   we: 1'b0, addr: 11'd935};
    vt[7]  = '{n: 13,   we: 1'b1, addr: 11'd1};
    vt[8]  = '{n: 193,  we: 1'b1, addr: 11'd16};
    vt[9]  = '{n: 205,  we: 1'b1, addr: 11'd0};
    vt[10] = '{n: 2243, we: 1'b1, addr: 11'd1121};
    vt[11] = '{n: 2255, we: 1'b1, addr: 11'd935};

    rst_i = 1'b1; valid_i = 1'b0; sync_i = 1'b0; data_i = 8'h00;
    reset_and_init(3);

    // Garbage before the first sync is dropped
    for (int i = 0; i < 50; i++) send(8'($urandom), 1'b0);

    // Gapless stream of 12 packets, byte k = k mod 256
    for (int n = 0; n < 12 * 204; n++) begin
      tbl_n = n;
      send(8'(n), (n % 204) == 0);
    end
    tbl_n = -1;

    // Misplaced sync at byte 100
    for (int i = 0; i < 100; i++) send(8'(i + 3), m_cnt == 0);
    send(DVBC_SYNC, 1'b1);
    @(negedge clk);
    chk("resync_err", 32'(sync_err_o), 1);
    chk("resync_sync", 32'(sync_o), 1);
    chk("resync_data", 32'(data_o), 32'(DVBC_SYNC));
    @(posedge clk); #1;
    @(negedge clk);
    chk("resync_err_pulse", 32'(sync_err_o), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 250; i++) send(8'($urandom), m_cnt == 0);

    // Random valid gaps, then reset mid-packet
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) send(8'($urandom), m_cnt == 0);
      else idle();
    end
    reset_and_init(2);
    for (int n = 0; n < 220; n++) send(8'(n ^ 8'h5A), m_cnt == 0);
    repeat (3) idle();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
